// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit framer state type.
// The CRC helpers here are also used by the GMII receive checker.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Payload byte stream into the transmit framer (valid/ready, last marks end of payload).
interface gmii_tx_framer_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/gmii_tx_framer_crc32_d8.sv
// Combinational CRC-32 (reflected 0xEDB88320) advance by one byte, LSB first.
// Shared with the GMII receive checker.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad to minimum size, FCS, IFG.
// Underrun or jabber aborts the frame by sending the uncomplemented CRC.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD = 60,
  parameter int MAX_PAYLOAD = 1514,
  parameter int IFG_BYTES   = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gmii_tx_framer_if.slave         s,
  output logic                    gmii_tx_en,
  output logic [7:0]              gmii_txd,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic                    tx_err
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES);
  localparam logic [7:0]  PRE_LAST = 8'd5;

  tx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  cyc_q, cyc_d;
  logic [31:0] crc_q, crc_d;
  logic        abort_q, abort_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [7:0]  crc_din;
  logic [31:0] crc_next;
  logic [31:0] fcs_word;
  logic [10:0] cnt_inc;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_din),
    .crc_out (crc_next)
  );

  // An aborted frame carries the raw register so the receiver sees a bad FCS.
  assign fcs_word = abort_q ? crc_q : ~crc_q;
  assign cnt_inc  = cnt_q + 11'd1;

  assign s.s_ready  = (state_q == ST_DATA);
  assign tx_busy    = (state_q != ST_IDLE);
  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign tx_done    = done_q;
  assign tx_err     = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    crc_d   = crc_q;
    abort_d = abort_q;
    tx_en_d = 1'b0;
    txd_d   = 8'h00;
    done_d  = 1'b0;
    err_d   = 1'b0;
    crc_din = s.s_data;

    unique case (state_q)
      ST_IDLE: begin
        crc_d   = CRC32_INIT;
        cnt_d   = '0;
        cyc_d   = '0;
        abort_d = 1'b0;
        if (s.s_valid) begin
          state_d = ST_PRE;
          tx_en_d = 1'b1;
          txd_d   = PREAMBLE_BYTE;
        end
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        txd_d   = PREAMBLE_BYTE;
        if (cyc_q == PRE_LAST) begin
          state_d = ST_SFD;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      ST_SFD: begin
        tx_en_d = 1'b1;
        txd_d   = SFD_BYTE;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_en_d = 1'b1;
        if (s.s_valid) begin
          txd_d = s.s_data;
          crc_d = crc_next;
          cnt_d = cnt_inc;
          cyc_d = '0;
          if (s.s_last) begin
            state_d = (cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
          end else if (cnt_inc == MAX_CNT) begin
            state_d = ST_FCS;
            abort_d = 1'b1;
          end
        end else begin
          // Underrun: the first abort FCS byte goes out right behind the last data byte.
          txd_d   = crc_q[7:0];
          abort_d = 1'b1;
          cyc_d   = 8'd1;
          state_d = ST_FCS;
        end
      end
      ST_PAD: begin
        tx_en_d = 1'b1;
        crc_din = 8'h00;
        crc_d   = crc_next;
        cnt_d   = cnt_inc;
        if (cnt_inc == MIN_CNT) begin
          state_d = ST_FCS;
          cyc_d   = '0;
        end
      end
      ST_FCS: begin
        tx_en_d = 1'b1;
        unique case (cyc_q[1:0])
          2'd0:    txd_d = fcs_word[7:0];
          2'd1:    txd_d = fcs_word[15:8];
          2'd2:    txd_d = fcs_word[23:16];
          default: txd_d = fcs_word[31:24];
        endcase
        if (cyc_q[1:0] == 2'd3) begin
          done_d  = ~abort_q;
          err_d   = abort_q;
          state_d = ST_IFG;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      ST_IFG: begin
        // The first IFG cycle still shows the last FCS byte, so IFG_BYTES+1 state cycles.
        if (cyc_q == IFG_LAST) state_d = ST_IDLE;
        else                   cyc_d   = cyc_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      crc_q   <= CRC32_INIT;
      abort_q <= 1'b0;
      tx_en_q <= 1'b0;
      txd_q   <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      crc_q   <= crc_d;
      abort_q <= abort_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed-sequence bench with random payloads, compared against a frame-level model.
module tb_gmii_tx_framer;
  import eth_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       tx_busy, tx_done, tx_err;

  gmii_tx_framer_if sif ();

  gmii_tx_framer #(
    .MIN_PAYLOAD (60),
    .MAX_PAYLOAD (1514),
    .IFG_BYTES   (12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (sif),
    .gmii_tx_en (gmii_tx_en),
    .gmii_txd   (gmii_txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] crc_tbl [256];
  logic [7:0]  pl_src [$];
  logic [7:0]  acc_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  cap [$];
  logic [7:0]  acc_a [$];
  logic [7:0]  acc_b [$];
  int          rdy_hi;
  logic        rdy_lim;

  // Line monitor
  int   cyc = 0;
  int   n_done, n_err, done_cyc, err_cyc, last_en_cyc, n_bursts, idle_run, last_gap;
  logic en_prev;

  always @(negedge clk) begin
    cyc++;
    if (gmii_tx_en === 1'b1) begin
      cap.push_back(gmii_txd);
      last_en_cyc = cyc;
      if (en_prev !== 1'b1) begin
        n_bursts++;
        last_gap = idle_run;
      end
      idle_run = 0;
    end else begin
      idle_run++;
    end
    if (tx_done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (tx_err === 1'b1)  begin n_err++;  err_cyc = cyc;  end
    en_prev = gmii_tx_en;
  end

  task automatic clear_mon();
    cap = {};
    n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
    last_en_cyc = -2; n_bursts = 0; idle_run = 0; last_gap = -1;
    en_prev = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc_reg_of(input logic [7:0] q[$]);
    logic [31:0] c;
    c = CRC32_INIT;
    foreach (q[i]) c = crc_tbl[c[7:0] ^ q[i]] ^ (c >> 8);
    return c;
  endfunction

  // Appends the expected on-wire bytes for the payload in acc_q.
  task automatic build_exp(input bit aborted);
    logic [7:0]  body [$];
    logic [31:0] r;
    logic [31:0] fcs;
    body = acc_q;
    if (!aborted) while (body.size() < 60) body.push_back(8'h00);
    r   = crc_reg_of(body);
    fcs = aborted ? r : ~r;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(fcs >> (8 * k)));
  endtask

  task automatic fill_random(input int n);
    pl_src = {};
    for (int i = 0; i < n; i++) pl_src.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic drive(input int n, input bit use_last, input int stop_at, input bit hold);
    int idx;
    int guard;
    logic acc;
    idx = 0;
    guard = 0;
    acc_q = {};
    while (idx < n && guard < 4000) begin
      sif.s_valid = 1'b1;
      sif.s_data  = pl_src[idx];
      sif.s_last  = use_last && (idx == n - 1);
      @(negedge clk);
      acc = sif.s_ready;
      if (idx == 1514) rdy_lim = acc;
      @(posedge clk); #1;
      guard++;
      if (idx == 1514 && !acc) break;
      if (acc) begin
        acc_q.push_back(pl_src[idx]);
        idx++;
      end
      if (idx == stop_at) break;
    end
    if (!hold) begin
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    rdy_hi = 0;
    while ((tx_busy !== 1'b0 || gmii_tx_en !== 1'b0) && g < 3000) begin
      if (sif.s_ready === 1'b1) rdy_hi++;
      @(posedge clk); #1;
      g++;
    end
    check({tag, "_idle_timeout"}, 32'(g < 3000), 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string tag, input bit aborted);
    int          nbad;
    logic [7:0]  w [$];
    logic [31:0] r;
    nbad = 0;
    check({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (i >= cap.size() || cap[i] !== exp_q[i]) nbad++;
    check({tag, "_bytes"}, 32'(nbad), 32'd0);
    w = {};
    for (int i = 8; i < cap.size(); i++) w.push_back(cap[i]);
    r = crc_reg_of(w);
    check({tag, "_residue_ok"}, 32'(r == CRC32_RESIDUE), 32'(!aborted));
    check({tag, "_done_cnt"}, 32'(n_done), aborted ? 32'd0 : 32'd1);
    check({tag, "_err_cnt"}, 32'(n_err), aborted ? 32'd1 : 32'd0);
    check({tag, "_flag_cyc"}, 32'(aborted ? err_cyc : done_cyc), 32'(last_en_cyc));
    check({tag, "_bursts"}, 32'(n_bursts), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    int          na, nb;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      crc_tbl[i] = c;
    end

    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    sif.s_data  = 8'h00;
    rdy_lim     = 1'b1;
    clear_mon();

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", 32'(gmii_tx_en), 32'd0);
    check("rst_txd", 32'(gmii_txd), 32'h00);
    check("rst_ready", 32'(sif.s_ready), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 64-byte counting payload
    pl_src = {};
    for (int i = 0; i < 64; i++) pl_src.push_back(8'(i));
    clear_mon();
    drive(64, 1'b1, -1, 1'b0);
    wait_idle("f64");
    exp_q = {};
    build_exp(1'b0);
    check("f64_txen_cycles", 32'(cap.size()), 32'd76);
    check_frame("f64", 1'b0);

    // 10-byte payload, padded
    fill_random(10);
    clear_mon();
    drive(10, 1'b1, -1, 1'b0);
    wait_idle("pad");
    check("pad_ready_after_last", 32'(rdy_hi), 32'd0);
    exp_q = {};
    build_exp(1'b0);
    check("pad_txen_cycles", 32'(cap.size()), 32'd72);
    check_frame("pad", 1'b0);

    // Back-to-back with s_valid held high
    na = $urandom_range(61, 100);
    nb = $urandom_range(20, 80);
    clear_mon();
    fill_random(na);
    drive(na, 1'b1, -1, 1'b1);
    acc_a = acc_q;
    fill_random(nb);
    drive(nb, 1'b1, -1, 1'b0);
    acc_b = acc_q;
    wait_idle("b2b");
    exp_q = {};
    acc_q = acc_a; build_exp(1'b0);
    acc_q = acc_b; build_exp(1'b0);
    check("b2b_len", 32'(cap.size()), 32'(exp_q.size()));
    na = 0;
    foreach (exp_q[i]) if (i >= cap.size() || cap[i] !== exp_q[i]) na++;
    check("b2b_bytes", 32'(na), 32'd0);
    check("b2b_bursts", 32'(n_bursts), 32'd2);
    check("b2b_gap", 32'(last_gap), 32'd13);
    check("b2b_done_cnt", 32'(n_done), 32'd2);
    check("b2b_err_cnt", 32'(n_err), 32'd0);

    // Underrun after 20 bytes
    fill_random(40);
    clear_mon();
    drive(40, 1'b1, 20, 1'b0);
    check("urun_accepted", 32'(acc_q.size()), 32'd20);
    wait_idle("urun");
    exp_q = {};
    build_exp(1'b1);
    check_frame("urun", 1'b1);

    // Jabber: 1515 bytes, no s_last
    fill_random(1515);
    clear_mon();
    rdy_lim = 1'b1;
    drive(1515, 1'b0, -1, 1'b0);
    check("jab_accepted", 32'(acc_q.size()), 32'd1514);
    check("jab_ready_1515th", 32'(rdy_lim), 32'd0);
    wait_idle("jab");
    exp_q = {};
    build_exp(1'b1);
    check_frame("jab", 1'b1);

    // Reset during cycle 30 of a frame
    sif.s_valid = 1'b1;
    sif.s_last  = 1'b0;
    sif.s_data  = 8'($urandom_range(0, 255));
    repeat (30) @(posedge clk);
    #2;
    check("mid_txen_before", 32'(gmii_tx_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_txen_async", 32'(gmii_tx_en), 32'd0);
    check("mid_ready_async", 32'(sif.s_ready), 32'd0);
    check("mid_busy_async", 32'(tx_busy), 32'd0);
    sif.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    fill_random(70);
    drive(70, 1'b1, -1, 1'b0);
    wait_idle("post_rst");
    exp_q = {};
    build_exp(1'b0);
    check_frame("post_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
